// File: rtl/bcd_updn_cnt.sv
// Multi-digit packed BCD up/down counter with load, clear and cascade outputs.
// Digit 0 is the least significant nibble. Carries ripple through all digits in one cycle.

module bcd_updn_digit (
  input  logic [3:0] d_i,
  input  logic       up_i,
  input  logic       dn_i,
  output logic [3:0] nxt_o,
  output logic       up_o,
  output logic       dn_o
);
  always_comb begin
    nxt_o = d_i;
    up_o  = 1'b0;
    dn_o  = 1'b0;
    if (up_i) begin
      if (d_i == 4'd9) begin
        nxt_o = 4'd0;
        up_o  = 1'b1;
      end else begin
        nxt_o = d_i + 4'd1;
      end
    end else if (dn_i) begin
      if (d_i == 4'd0) begin
        nxt_o = 4'd9;
        dn_o  = 1'b1;
      end else begin
        nxt_o = d_i - 4'd1;
      end
    end
  end
endmodule

module bcd_updn_cnt #(
  parameter int DIGITS = 4,
  parameter int SAT    = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  inc,
  input  logic                  dec,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  TC,
  output logic                  BC,
  output logic                  load_err
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0]    q_d, q_q, nxt;
  logic            err_d, err_q;
  logic            step_up, step_dn, din_ok;
  logic [DIGITS:0] cy, bw;

  assign step_up = inc & ~dec & ~load & ~clr;
  assign step_dn = dec & ~inc & ~load & ~clr;
  assign cy[0]   = step_up;
  assign bw[0]   = step_dn;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_updn_digit u_dig (
      .d_i   (q_q[4*g +: 4]),
      .up_i  (cy[g]),
      .dn_i  (bw[g]),
      .nxt_o (nxt[4*g +: 4]),
      .up_o  (cy[g+1]),
      .dn_o  (bw[g+1])
    );
  end

  // A carry out of the top digit only happens when every digit was 9 (or 0 for borrow).
  assign TC = cy[DIGITS];
  assign BC = bw[DIGITS];

  always_comb begin
    din_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (din[4*i +: 4] > 4'd9) din_ok = 1'b0;
  end

  always_comb begin
    q_d   = q_q;
    err_d = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      if (din_ok) q_d = din;
      else        err_d = 1'b1;
    end else if ((TC || BC) && (SAT != 0)) begin
      q_d = q_q;
    end else begin
      q_d = nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_q   <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign Q        = q_q;
  assign load_err = err_q;
endmodule

// File: tb/tb_bcd_updn_cnt.sv
// Directed bench for bcd_updn_cnt: a wrapping and a saturating instance share stimulus.
// Table vectors cover the main function; hand sequences cover reset and rstn glitches.

module tb_bcd_updn_cnt;
  logic        clk = 1'b0;
  logic        rstn, clr, load, inc, dec;
  logic [15:0] din;
  logic [15:0] q_w, q_s;
  logic        tc_w, bc_w, err_w, tc_s, bc_s, err_s;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  bcd_updn_cnt #(.DIGITS(4), .SAT(0)) u_wrap (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .din(din), .inc(inc), .dec(dec),
    .Q(q_w), .TC(tc_w), .BC(bc_w), .load_err(err_w)
  );

  bcd_updn_cnt #(.DIGITS(4), .SAT(1)) u_sat (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .din(din), .inc(inc), .dec(dec),
    .Q(q_s), .TC(tc_s), .BC(bc_s), .load_err(err_s)
  );

  typedef struct packed {
    logic        rstn, clr, load;
    logic [15:0] din;
    logic        inc, dec;
    logic [15:0] qw, qs;
    logic        tc, bc, err;
  } vec_t;

  vec_t vec [26];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    //            rstn  clr   load  din       inc   dec   qw        qs        tc    bc    err
    vec[0]  = '{1'b1, 1'b0, 1'b1, 16'h0998, 1'b0, 1'b0, 16'h0998, 16'h0998, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0999, 16'h0999, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{1'b1, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 16'h9999, 16'h9999, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h9999, 1'b1, 1'b0, 1'b0};
    vec[5]  = '{1'b1, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0999, 16'h0999, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vec[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h9999, 16'h0000, 1'b0, 1'b1, 1'b0};
    vec[9]  = '{1'b1, 1'b0, 1'b1, 16'h12A4, 1'b0, 1'b0, 16'h9999, 16'h0000, 1'b0, 1'b0, 1'b1};
    vec[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h9999, 16'h0000, 1'b0, 1'b0, 1'b0};
    vec[11] = '{1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0};
    vec[12] = '{1'b1, 1'b0, 1'b1, 16'h0500, 1'b0, 1'b0, 16'h0500, 16'h0500, 1'b0, 1'b0, 1'b0};
    vec[13] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0500, 16'h0500, 1'b0, 1'b0, 1'b0};
    vec[14] = '{1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vec[15] = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vec[16] = '{1'b1, 1'b0, 1'b1, 16'h9989, 1'b0, 1'b0, 16'h9989, 16'h9989, 1'b0, 1'b0, 1'b0};
    vec[17] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h9990, 16'h9990, 1'b0, 1'b0, 1'b0};
    vec[18] = '{1'b1, 1'b0, 1'b1, 16'h0900, 1'b0, 1'b0, 16'h0900, 16'h0900, 1'b0, 1'b0, 1'b0};
    vec[19] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0899, 16'h0899, 1'b0, 1'b0, 1'b0};
    vec[20] = '{1'b1, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 16'h9999, 16'h9999, 1'b0, 1'b0, 1'b0};
    vec[21] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h9999, 16'h9999, 1'b0, 1'b0, 1'b0};
    vec[22] = '{1'b1, 1'b0, 1'b1, 16'h0437, 1'b0, 1'b0, 16'h0437, 16'h0437, 1'b0, 1'b0, 1'b0};
    vec[23] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vec[24] = '{1'b0, 1'b0, 1'b1, 16'hF000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vec[25] = '{1'b1, 1'b0, 1'b1, 16'h0437, 1'b0, 1'b0, 16'h0437, 16'h0437, 1'b0, 1'b0, 1'b0};

    // Reset wins over inc and load.
    rstn = 1'b0; clr = 1'b0; load = 1'b1; din = 16'h1234; inc = 1'b1; dec = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q_w", q_w, 16'h0000);
    chk("rst_q_s", q_s, 16'h0000);
    chk("rst_err", {15'd0, err_w}, 16'd0);
    chk("rst_tc",  {15'd0, tc_w},  16'd0);

    @(negedge clk);
    rstn = 1'b1; load = 1'b0; din = 16'h0000; inc = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("cnt12_w", q_w, 16'h0012);
    chk("cnt12_s", q_s, 16'h0012);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      rstn = vec[i].rstn; clr = vec[i].clr; load = vec[i].load;
      din  = vec[i].din;  inc = vec[i].inc; dec  = vec[i].dec;
      #1;
      chk($sformatf("v%0d_tc_w", i), {15'd0, tc_w}, {15'd0, vec[i].tc});
      chk($sformatf("v%0d_bc_w", i), {15'd0, bc_w}, {15'd0, vec[i].bc});
      chk($sformatf("v%0d_tc_s", i), {15'd0, tc_s}, {15'd0, vec[i].tc});
      chk($sformatf("v%0d_bc_s", i), {15'd0, bc_s}, {15'd0, vec[i].bc});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_q_w", i),   q_w, vec[i].qw);
      chk($sformatf("v%0d_q_s", i),   q_s, vec[i].qs);
      chk($sformatf("v%0d_err_w", i), {15'd0, err_w}, {15'd0, vec[i].err});
      chk($sformatf("v%0d_err_s", i), {15'd0, err_s}, {15'd0, vec[i].err});
    end

    // rstn pulsed low between edges must not disturb the count.
    @(negedge clk);
    rstn = 1'b1; clr = 1'b0; load = 1'b0; inc = 1'b1; dec = 1'b0;
    #1 rstn = 1'b0;
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("glitch_q_w", q_w, 16'h0438);
    chk("glitch_q_s", q_s, 16'h0438);

    @(negedge clk);
    inc = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
